// File: rtl/pll_lock_sequencer_if.sv
// Control and status bundle between the PLL lock sequencer and the surrounding clocking logic.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       pll_fail;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;

    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output sys_rst_n,
        output pll_ready,
        output pll_fail,
        output retry_cnt,
        output lost_cnt
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  sys_rst_n,
        input  pll_ready,
        input  pll_fail,
        input  retry_cnt,
        input  lost_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Drives the rPLL reset, filters its LOCK output and holds the downstream reset until lock is stable.
// Re-locks on loss of lock or request; gives up into FAIL after MAX_RETRIES lock timeouts.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_sequencer_if.master bus
);
    localparam int MAX_AB  = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    // One spare count above the limit: WAIT_LOCK may hand over to STABLE exactly at the limit.
    localparam int TW      = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_lock_meta;
    logic            r_lock_s;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [TW-1:0]   r_tmo;
    logic [TW-1:0]   w_tmo_nxt;
    logic [7:0]      r_retry_cnt;
    logic [7:0]      w_retry_nxt;
    logic [7:0]      r_lost_cnt;
    logic [7:0]      w_lost_nxt;
    logic [7:0]      w_retry_inc;
    logic            w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_retry_cnt <= '0;
            r_lost_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tmo       <= w_tmo_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_lost_cnt  <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_retry_nxt = r_retry_cnt;
        w_lost_nxt  = r_lost_cnt;
        w_retry_inc = r_retry_cnt + 8'd1;
        w_timeout   = 1'b0;

        case (r_state)
            S_RESET: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_LOCK: begin
                w_tmo_nxt = r_tmo + TW'(1);
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_tmo >= TMO_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            S_STABLE: begin
                // Timeout outranks both a glitch and a completed stability count.
                w_tmo_nxt = r_tmo + TW'(1);
                if (r_tmo >= TMO_LAST) begin
                    w_timeout = 1'b1;
                end else if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STB_LAST) begin
                    w_state_nxt = S_RUN;
                    w_retry_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = '0;
                    if (r_lost_cnt != 8'hFF) begin
                        w_lost_nxt = r_lost_cnt + 8'd1;
                    end
                end else if (bus.relock_req) begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = '0;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_timeout) begin
            w_retry_nxt = w_retry_inc;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
        end
    end

    assign bus.pll_reset = (r_state == S_RESET) || (r_state == S_FAIL);
    assign bus.sys_rst_n = (r_state == S_RUN);
    assign bus.pll_ready = (r_state == S_RUN);
    assign bus.pll_fail  = (r_state == S_FAIL);
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.lost_cnt  = r_lost_cnt;
endmodule
